// File: rtl/sc_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake, advances on commit.
// Latency: req one cycle after reset release; 2 cycles per instruction with zero-wait memory and immediate commit.
// Backpressure: stalls in FETCH until imem_ack and in EXEC until commit; each stall cycle adds one cycle.
module sc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] inst,
  output logic [11:0] op,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic [1:0]  pcsource,
  input  logic [31:0] rs_data,
  input  logic        commit,
  output logic        align_err,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        inst_valid_q;
  logic        align_err_q;
  logic [31:0] retired_q;

  logic        take_ack;
  logic        take_commit;
  logic        jr_misaligned;
  logic [31:0] next_pc;
  logic [31:0] br_off;

  // Next-state decode; the handshake strobes are qualified by state so stray
  // acks/commits outside their owning state have no effect.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    take_ack    = 1'b0;
    take_commit = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          take_ack = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (commit) begin
          take_commit = 1'b1;
          state_d     = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next-PC selection; all arithmetic wraps modulo 2^32.
  always_comb begin
    pc4           = pc_q + 32'd4;
    br_off        = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    jr_misaligned = 1'b0;
    next_pc       = pc4;
    case (pcsource)
      2'b00: next_pc = pc4;
      2'b01: next_pc = pc4 + br_off;
      2'b10: begin
        next_pc       = {rs_data[31:2], 2'b00};
        jr_misaligned = (rs_data[1:0] != 2'b00);
      end
      2'b11: next_pc = {pc4[31:28], inst_q[25:0], 2'b00};
      default: next_pc = pc4;
    endcase
  end

  // State, PC, instruction latch and counters; reset wins over a same-cycle commit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
      retired_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (take_ack) begin
        inst_q       <= imem_rdata;
        inst_valid_q <= 1'b1;
      end
      if (take_commit) begin
        pc_q         <= next_pc;
        inst_valid_q <= 1'b0;
        retired_q    <= retired_q + 32'd1;
        if (jr_misaligned) begin
          align_err_q <= 1'b1;
        end
      end
    end
  end

  // Output wiring; the fetch address is the PC itself.
  always_comb begin
    imem_addr  = pc_q;
    pc         = pc_q;
    inst       = inst_q;
    op         = {inst_q[31:26], inst_q[5:0]};
    inst_valid = inst_valid_q;
    align_err  = align_err_q;
    retired    = retired_q;
  end

endmodule

// File: tb/tb_sc_fetch.sv
// Directed bench for sc_fetch: inputs change on the falling edge, outputs are checked on the falling edge.
// Expected values are hand-computed constants plus a tracked retire count.
// Memory responses are driven directly by the bench.
module tb_sc_fetch;

  logic        clk;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] inst;
  logic [11:0] op;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [1:0]  pcsource;
  logic [31:0] rs_data;
  logic        commit;
  logic        align_err;
  logic [31:0] retired;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_retired;

  sc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .inst       (inst),
    .op         (op),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .pcsource   (pcsource),
    .rs_data    (rs_data),
    .commit     (commit),
    .align_err  (align_err),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Serve one fetch at exp_pc after 'waits' stall cycles, then check the latched word.
  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data, input int waits);
    chk("req_in_fetch", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    chk("valid_in_fetch", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      step();
      chk("wait_req_held", {31'd0, imem_req}, 32'd1);
      chk("wait_addr_held", imem_addr, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("inst_latched", inst, data);
    chk("op_field", {20'd0, op}, {20'd0, data[31:26], data[5:0]});
    chk("valid_in_exec", {31'd0, inst_valid}, 32'd1);
    chk("req_in_exec", {31'd0, imem_req}, 32'd0);
  endtask

  // Commit the instruction in EXEC and check the resulting PC and retire count.
  task automatic do_commit(input logic [1:0] sel, input logic [31:0] rs, input logic [31:0] exp_next);
    commit   = 1'b1;
    pcsource = sel;
    rs_data  = rs;
    step();
    commit   = 1'b0;
    pcsource = 2'b00;
    rs_data  = 32'h0;
    exp_retired = exp_retired + 32'd1;
    chk("next_pc", pc, exp_next);
    chk("retired", retired, exp_retired);
    chk("valid_after_commit", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] keep_inst;
    vectors     = 0;
    miscompares = 0;
    exp_retired = 32'd0;
    resetn      = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    pcsource    = 2'b00;
    rs_data     = 32'h0;
    commit      = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_op", {20'd0, op}, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_align", {31'd0, align_err}, 32'd0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_pc4", pc4, 32'h4);

    // First request one cycle after release
    resetn = 1'b1;
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);

    // Sequential fetch 0,4,8,12
    do_fetch(32'h0,  32'h2001_0001, 0);
    do_commit(2'b00, 32'h0, 32'h4);
    do_fetch(32'h4,  32'h2002_0002, 0);
    do_commit(2'b00, 32'h0, 32'h8);
    do_fetch(32'h8,  32'h2003_0003, 0);
    do_commit(2'b00, 32'h0, 32'hC);
    do_fetch(32'hC,  32'h2004_0004, 0);
    do_commit(2'b00, 32'h0, 32'h10);
    chk("retired_four", retired, 32'd4);

    // Three wait states; op = {100011,101010} = 0x8EA
    do_fetch(32'h10, 32'h8C41_002A, 3);
    chk("op_const", {20'd0, op}, 32'h8EA);
    do_commit(2'b00, 32'h0, 32'h14);

    // Aligned jr to 0x100 leaves align_err clear
    do_fetch(32'h14, 32'h03E0_0008, 0);
    do_commit(2'b10, 32'h0000_0100, 32'h100);
    chk("align_clear", {31'd0, align_err}, 32'd0);

    // Branch with imm=0xFFFF: 0x104 - 4 = 0x100
    do_fetch(32'h100, 32'h1000_FFFF, 0);
    do_commit(2'b01, 32'h0, 32'h100);

    // Jump from 0x1000_0000 with target 0x40 -> 0x1000_0100
    do_fetch(32'h100, 32'h03E0_0008, 0);
    do_commit(2'b10, 32'h1000_0000, 32'h1000_0000);
    do_fetch(32'h1000_0000, 32'h0800_0040, 0);
    chk("pc4_mid", pc4, 32'h1000_0004);
    do_commit(2'b11, 32'h0, 32'h1000_0100);

    // PC wrap from 0xFFFF_FFFC
    do_fetch(32'h1000_0100, 32'h03E0_0008, 0);
    do_commit(2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 0);
    chk("pc4_wrap", pc4, 32'h0);
    do_commit(2'b00, 32'h0, 32'h0);

    // Misaligned jr sets align_err; following aligned jr keeps it
    do_fetch(32'h0, 32'h03E0_0008, 0);
    do_commit(2'b10, 32'h0000_2003, 32'h2000);
    chk("align_set", {31'd0, align_err}, 32'd1);
    do_fetch(32'h2000, 32'h03E0_0008, 0);
    do_commit(2'b10, 32'h0000_3000, 32'h3000);
    chk("align_sticky", {31'd0, align_err}, 32'd1);

    // Spurious commit in FETCH
    keep_inst = inst;
    commit   = 1'b1;
    pcsource = 2'b11;
    step();
    commit   = 1'b0;
    pcsource = 2'b00;
    chk("spur_commit_pc", pc, 32'h3000);
    chk("spur_commit_ret", retired, exp_retired);
    chk("spur_commit_inst", inst, keep_inst);
    // Spurious ack in EXEC
    do_fetch(32'h3000, 32'h1234_5678, 0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    step();
    imem_ack   = 1'b0;
    chk("spur_ack_inst", inst, 32'h1234_5678);
    chk("spur_ack_pc", pc, 32'h3000);
    chk("spur_ack_ret", retired, exp_retired);
    chk("spur_ack_valid", {31'd0, inst_valid}, 32'd1);
    do_commit(2'b00, 32'h0, 32'h3004);

    // Reset mid-fetch with ack one cycle later
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    resetn = 1'b0;
    step();
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    resetn     = 1'b1;
    step();
    imem_ack    = 1'b0;
    exp_retired = 32'd0;
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_ret", retired, 32'h0);
    chk("midrst_align", {31'd0, align_err}, 32'd0);
    do_fetch(32'h0, 32'h2005_0005, 0);

    // Commit coinciding with reset: reset wins
    commit = 1'b1;
    resetn = 1'b0;
    step();
    commit = 1'b0;
    resetn = 1'b1;
    chk("rst_commit_ret", retired, 32'h0);
    chk("rst_commit_pc", pc, 32'h0);
    chk("rst_commit_valid", {31'd0, inst_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
